stream_mux_rr: RTL and testbench

- Parametrised N-channel streaming selector; next generation of the team's 4:1 combinational mux.
- Adds valid/ready handshake per channel, round-robin arbitration, and a forced-select mode.
- Adds packet locking on a last flag and one registered output stage.
- Sits between multiple producer streams and a single consumer. Examples: DMA channel merge, debug trace funnel.

---
 rtl/stream_mux_pkg.sv | 13 +
 rtl/rr_arbiter.sv | 32 +++
 rtl/stream_mux_rr.sv | 116 +++++++++++
 tb/tb_stream_mux_rr.sv | 349 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/stream_mux_pkg.sv
// Shared types and helpers for the round-robin stream multiplexer.
package stream_mux_pkg;

  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } state_t;

  function automatic int sel_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational rotate-priority encoder: scans from ptr+1 upward, wrapping, so ptr itself is checked last.
module rr_arbiter
  import stream_mux_pkg::*;
#(
  parameter int N_CH  = 4,
  parameter int SEL_W = sel_w(N_CH)
) (
  input  logic [N_CH-1:0]  req,
  input  logic [SEL_W-1:0] ptr,
  output logic [N_CH-1:0]  grant,
  output logic [SEL_W-1:0] grant_idx
);

  logic             found;
  logic [SEL_W-1:0] idx;

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    idx       = '0;
    for (int k = 1; k <= N_CH; k++) begin
      idx = SEL_W'((int'(ptr) + k) % N_CH);
      if (!found && req[idx]) begin
        found      = 1'b1;
        grant[idx] = 1'b1;
        grant_idx  = idx;
      end
    end
  end

endmodule

// File: rtl/stream_mux_rr.sv
// N-channel valid/ready stream mux with round-robin or forced selection, packet locking on last,
// and one registered output stage (1-cycle latency, full throughput while out_ready is high).
module stream_mux_rr
  import stream_mux_pkg::*;
#(
  parameter int N_CH   = 4,
  parameter int DATA_W = 8,
  parameter int SEL_W  = sel_w(N_CH)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [N_CH-1:0]          in_valid,
  output logic [N_CH-1:0]          in_ready,
  input  logic [N_CH*DATA_W-1:0]   in_data,
  input  logic [N_CH-1:0]          in_last,
  input  logic                     force_en,
  input  logic [SEL_W-1:0]         force_sel,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [DATA_W-1:0]        out_data,
  output logic                     out_last,
  output logic [SEL_W-1:0]         out_ch
);

  state_t            state_q, state_d;
  logic [SEL_W-1:0]  lock_ch_q, lock_ch_d;
  logic [SEL_W-1:0]  rr_ptr_q, rr_ptr_d;
  logic              out_valid_q, out_valid_d;
  logic [DATA_W-1:0] out_data_q, out_data_d;
  logic              out_last_q, out_last_d;
  logic [SEL_W-1:0]  out_ch_q, out_ch_d;

  logic [N_CH-1:0]   req_mask;
  logic [N_CH-1:0]   grant;
  logic [SEL_W-1:0]  grant_idx;
  logic              load;
  logic              xfer;

  // Eligibility: the locked channel, the forced channel (none if out of range), or everyone.
  always_comb begin
    req_mask = '0;
    if (state_q == LOCKED) begin
      req_mask[lock_ch_q] = 1'b1;
    end else if (force_en) begin
      for (int i = 0; i < N_CH; i++) begin
        if (force_sel == SEL_W'(i)) req_mask[i] = 1'b1;
      end
    end else begin
      req_mask = '1;
    end
  end

  rr_arbiter #(
    .N_CH  (N_CH),
    .SEL_W (SEL_W)
  ) u_arb (
    .req       (in_valid & req_mask),
    .ptr       (rr_ptr_q),
    .grant     (grant),
    .grant_idx (grant_idx)
  );

  assign load     = !out_valid_q || out_ready;
  assign in_ready = load ? grant : '0;
  assign xfer     = |in_ready;

  always_comb begin
    state_d     = state_q;
    lock_ch_d   = lock_ch_q;
    rr_ptr_d    = rr_ptr_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_last_d  = out_last_q;
    out_ch_d    = out_ch_q;
    if (load) out_valid_d = xfer;
    if (xfer) begin
      out_data_d = in_data[int'(grant_idx)*DATA_W +: DATA_W];
      out_last_d = in_last[grant_idx];
      out_ch_d   = grant_idx;
      rr_ptr_d   = grant_idx;
      if (state_q == IDLE && !in_last[grant_idx]) begin
        state_d   = LOCKED;
        lock_ch_d = grant_idx;
      end else if (state_q == LOCKED && in_last[grant_idx]) begin
        state_d = IDLE;
      end
    end
  end

  // Reset pointer to the last channel so channel 0 wins the first arbitration.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      lock_ch_q   <= '0;
      rr_ptr_q    <= SEL_W'(N_CH - 1);
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_last_q  <= 1'b0;
      out_ch_q    <= '0;
    end else begin
      state_q     <= state_d;
      lock_ch_q   <= lock_ch_d;
      rr_ptr_q    <= rr_ptr_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_last_q  <= out_last_d;
      out_ch_q    <= out_ch_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_last  = out_last_q;
  assign out_ch    = out_ch_q;

endmodule

// File: tb/tb_stream_mux_rr.sv
// Bench for stream_mux_rr: directed scenario tasks plus a scoreboard of accepted beats.
module tb_stream_mux_rr;

  logic        clk = 1'b0;
  logic        rst;

  // 4-channel instance
  logic [3:0]  in_valid, in_ready, in_last;
  logic [31:0] in_data;
  logic        force_en, out_ready, out_valid, out_last;
  logic [1:0]  force_sel, out_ch;
  logic [7:0]  out_data;

  // 3-channel instance (out-of-range force index)
  logic [2:0]  in_valid3, in_ready3, in_last3;
  logic [23:0] in_data3;
  logic        force_en3, out_ready3, out_valid3, out_last3;
  logic [1:0]  force_sel3, out_ch3;
  logic [7:0]  out_data3;

  // 1-channel instance
  logic        in_valid1, in_ready1, in_last1;
  logic [7:0]  in_data1, out_data1;
  logic        force_en1, out_ready1, out_valid1, out_last1;
  logic [0:0]  force_sel1, out_ch1;

  int checks   = 0;
  int failures = 0;
  logic [10:0] sb[$];
  logic [10:0] exp_beat;

  always #5 clk = ~clk;

  stream_mux_rr #(.N_CH(4), .DATA_W(8)) u_dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_last(in_last), .force_en(force_en), .force_sel(force_sel), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data), .out_last(out_last), .out_ch(out_ch)
  );

  stream_mux_rr #(.N_CH(3), .DATA_W(8)) u_dut3 (
    .clk(clk), .rst(rst), .in_valid(in_valid3), .in_ready(in_ready3), .in_data(in_data3),
    .in_last(in_last3), .force_en(force_en3), .force_sel(force_sel3), .out_valid(out_valid3),
    .out_ready(out_ready3), .out_data(out_data3), .out_last(out_last3), .out_ch(out_ch3)
  );

  stream_mux_rr #(.N_CH(1), .DATA_W(8)) u_dut1 (
    .clk(clk), .rst(rst), .in_valid(in_valid1), .in_ready(in_ready1), .in_data(in_data1),
    .in_last(in_last1), .force_en(force_en1), .force_sel(force_sel1), .out_valid(out_valid1),
    .out_ready(out_ready1), .out_data(out_data1), .out_last(out_last1), .out_ch(out_ch1)
  );

  // Scoreboard: beats are pushed when accepted and must emerge in order on out_*.
  always @(negedge clk) begin
    if (rst) begin
      sb.delete();
    end else begin
      if (out_valid && out_ready) begin
        checks++;
        if (sb.size() == 0) begin
          failures++;
          $display("FAIL sb_unexpected: got ch=%0d last=%0b data=%h, nothing expected",
                   out_ch, out_last, out_data);
        end else begin
          exp_beat = sb.pop_front();
          if ({out_ch, out_last, out_data} !== exp_beat) begin
            failures++;
            $display("FAIL sb_beat: got ch=%0d last=%0b data=%h, want ch=%0d last=%0b data=%h",
                     out_ch, out_last, out_data, exp_beat[10:9], exp_beat[8], exp_beat[7:0]);
          end
        end
      end
      checks++;
      if (!$onehot0(in_ready) || $isunknown(in_ready)) begin
        failures++;
        $display("FAIL onehot0: in_ready=%b", in_ready);
      end
      for (int i = 0; i < 4; i++) begin
        if (in_valid[i] && in_ready[i]) sb.push_back({2'(i), in_last[i], in_data[i*8 +: 8]});
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    in_valid = '0; in_last = '0; in_data = '0; force_en = 1'b0; force_sel = '0; out_ready = 1'b0;
    in_valid3 = '0; in_last3 = '0; in_data3 = '0; force_en3 = 1'b0; force_sel3 = '0; out_ready3 = 1'b0;
    in_valid1 = 1'b0; in_last1 = 1'b0; in_data1 = '0; force_en1 = 1'b0; force_sel1 = '0; out_ready1 = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    #1;
    checks++;
    if ({out_valid, out_last, out_ch, out_data, in_ready} !== 16'h0) begin
      failures++;
      $display("FAIL reset_outputs: valid=%b last=%b ch=%b data=%h rdy=%b, want all 0",
               out_valid, out_last, out_ch, out_data, in_ready);
    end
    checks++;
    if (out_valid3 !== 1'b0 || out_valid1 !== 1'b0) begin
      failures++;
      $display("FAIL reset_small: out_valid3=%b out_valid1=%b, want 0 0", out_valid3, out_valid1);
    end
  endtask

  task automatic test_rr_single();
    logic [3:0] exp_rdy;
    in_data = 32'hA3A2A1A0; in_last = 4'hF; in_valid = 4'hF; out_ready = 1'b1;
    #1;
    for (int k = 0; k < 5; k++) begin
      exp_rdy = 4'b0001 << (k % 4);
      checks++;
      if (in_ready !== exp_rdy) begin
        failures++;
        $display("FAIL rr_ready[%0d]: got %b want %b", k, in_ready, exp_rdy);
      end
      tick();
      checks++;
      if (out_valid !== 1'b1 || out_ch !== 2'(k % 4) || out_data !== 8'(8'hA0 + k % 4)) begin
        failures++;
        $display("FAIL rr_out[%0d]: valid=%b ch=%0d data=%h, want 1 %0d %h",
                 k, out_valid, out_ch, out_data, k % 4, 8'(8'hA0 + k % 4));
      end
    end
    in_valid = '0;
    tick();
    checks++;
    if (out_valid !== 1'b0 || out_ch !== 2'd0 || out_data !== 8'hA0) begin
      failures++;
      $display("FAIL rr_idle: valid=%b ch=%0d data=%h, want 0 0 a0", out_valid, out_ch, out_data);
    end
  endtask

  task automatic test_lock();
    in_data = 32'h00000000 | {8'h0, 8'h0, 8'hB1, 8'hB0};
    in_valid = 4'b0010; in_last = 4'hF;
    tick();                                  // ch1 single beat moves pointer to 1
    in_valid = 4'b0111; in_last = 4'b0011; in_data[23:16] = 8'hC0;
    #1;
    checks++;
    if (in_ready !== 4'b0100) begin failures++; $display("FAIL lock_first_rdy: got %b want 0100", in_ready); end
    tick();
    checks++;
    if (out_ch !== 2'd2 || out_last !== 1'b0 || out_data !== 8'hC0) begin
      failures++;
      $display("FAIL lock_beat1: ch=%0d last=%b data=%h, want 2 0 c0", out_ch, out_last, out_data);
    end
    in_valid = 4'b0011; in_data[23:16] = 8'hC1;
    #1;
    checks++;
    if (in_ready !== 4'b0000) begin failures++; $display("FAIL lock_stall_rdy: got %b want 0000", in_ready); end
    tick();
    checks++;
    if (out_valid !== 1'b0) begin failures++; $display("FAIL lock_stall_valid: got %b want 0", out_valid); end
    in_valid = 4'b0111;
    #1;
    checks++;
    if (in_ready !== 4'b0100) begin failures++; $display("FAIL lock_beat2_rdy: got %b want 0100", in_ready); end
    tick();
    checks++;
    if (out_ch !== 2'd2 || out_data !== 8'hC1) begin
      failures++;
      $display("FAIL lock_beat2: ch=%0d data=%h, want 2 c1", out_ch, out_data);
    end
    in_data[23:16] = 8'hC2; in_last = 4'b0111;
    #1;
    checks++;
    if (in_ready !== 4'b0100) begin failures++; $display("FAIL lock_beat3_rdy: got %b want 0100", in_ready); end
    tick();
    checks++;
    if (out_ch !== 2'd2 || out_last !== 1'b1 || out_data !== 8'hC2) begin
      failures++;
      $display("FAIL lock_beat3: ch=%0d last=%b data=%h, want 2 1 c2", out_ch, out_last, out_data);
    end
    in_valid = 4'b0011; in_last = 4'b0011;
    #1;
    checks++;
    if (in_ready !== 4'b0001) begin failures++; $display("FAIL lock_release_rdy: got %b want 0001", in_ready); end
    tick();
    checks++;
    if (out_ch !== 2'd0 || out_data !== 8'hB0) begin
      failures++;
      $display("FAIL lock_release: ch=%0d data=%h, want 0 b0", out_ch, out_data);
    end
    in_valid = '0;
    tick();
  endtask

  task automatic test_backpressure();
    in_data = 32'hC3D2D1D0; in_valid = 4'b1000; in_last = 4'hF; out_ready = 1'b1;
    tick();
    in_valid = 4'hF; out_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      #1;
      checks++;
      if (in_ready !== 4'b0000) begin failures++; $display("FAIL bp_rdy[%0d]: got %b want 0000", k, in_ready); end
      tick();
      checks++;
      if (out_valid !== 1'b1 || out_ch !== 2'd3 || out_last !== 1'b1 || out_data !== 8'hC3) begin
        failures++;
        $display("FAIL bp_hold[%0d]: valid=%b ch=%0d last=%b data=%h, want 1 3 1 c3",
                 k, out_valid, out_ch, out_last, out_data);
      end
    end
    out_ready = 1'b1;
    #1;
    checks++;
    if (in_ready !== 4'b0001) begin failures++; $display("FAIL bp_resume_rdy: got %b want 0001", in_ready); end
    tick();
    checks++;
    if (out_ch !== 2'd0 || out_data !== 8'hD0) begin
      failures++;
      $display("FAIL bp_resume: ch=%0d data=%h, want 0 d0", out_ch, out_data);
    end
    in_valid = '0;
    tick();
  endtask

  task automatic test_force();
    in_data = 32'hE3E2E1E0; in_valid = 4'hF; in_last = 4'b0111;
    force_en = 1'b1; force_sel = 2'd3;
    #1;
    checks++;
    if (in_ready !== 4'b1000) begin failures++; $display("FAIL force_rdy: got %b want 1000", in_ready); end
    tick();
    force_sel = 2'd1;
    #1;
    checks++;
    if (in_ready !== 4'b1000 || out_ch !== 2'd3) begin
      failures++;
      $display("FAIL force_locked: rdy=%b ch=%0d, want 1000 3", in_ready, out_ch);
    end
    tick();
    in_last = 4'hF;
    #1;
    checks++;
    if (in_ready !== 4'b1000) begin failures++; $display("FAIL force_last_rdy: got %b want 1000", in_ready); end
    tick();
    checks++;
    if (out_ch !== 2'd3 || out_last !== 1'b1 || in_ready !== 4'b0010) begin
      failures++;
      $display("FAIL force_switch: ch=%0d last=%b rdy=%b, want 3 1 0010", out_ch, out_last, in_ready);
    end
    tick();
    checks++;
    if (out_ch !== 2'd1 || out_data !== 8'hE1) begin
      failures++;
      $display("FAIL force_ch1: ch=%0d data=%h, want 1 e1", out_ch, out_data);
    end
    force_en = 1'b0; in_valid = '0;
    tick();
    in_data3 = 24'hF2F1F0; in_valid3 = 3'b111; in_last3 = 3'b111; out_ready3 = 1'b1;
    force_en3 = 1'b1; force_sel3 = 2'd3;
    #1;
    checks++;
    if (in_ready3 !== 3'b000) begin failures++; $display("FAIL force_oor_rdy: got %b want 000", in_ready3); end
    tick();
    checks++;
    if (out_valid3 !== 1'b0) begin failures++; $display("FAIL force_oor_valid: got %b want 0", out_valid3); end
    force_sel3 = 2'd2;
    #1;
    checks++;
    if (in_ready3 !== 3'b100) begin failures++; $display("FAIL force3_rdy: got %b want 100", in_ready3); end
    tick();
    checks++;
    if (out_valid3 !== 1'b1 || out_ch3 !== 2'd2 || out_data3 !== 8'hF2) begin
      failures++;
      $display("FAIL force3_out: valid=%b ch=%0d data=%h, want 1 2 f2", out_valid3, out_ch3, out_data3);
    end
    in_valid3 = '0; force_en3 = 1'b0;
  endtask

  task automatic test_reset_mid_packet();
    in_data = 32'h13121110; in_valid = 4'b0010; in_last = 4'b0000; out_ready = 1'b1;
    tick();
    checks++;
    if (out_valid !== 1'b1 || out_ch !== 2'd1) begin
      failures++;
      $display("FAIL rstmid_pre: valid=%b ch=%0d, want 1 1", out_valid, out_ch);
    end
    out_ready = 1'b0; rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || out_ch !== 2'd0) begin
      failures++;
      $display("FAIL rstmid_flush: valid=%b ch=%0d, want 0 0", out_valid, out_ch);
    end
    in_valid = 4'hF; in_last = 4'hF; out_ready = 1'b1;
    #1;
    checks++;
    if (in_ready !== 4'b0001) begin failures++; $display("FAIL rstmid_rdy: got %b want 0001", in_ready); end
    tick();
    checks++;
    if (out_ch !== 2'd0 || out_data !== 8'h10) begin
      failures++;
      $display("FAIL rstmid_first: ch=%0d data=%h, want 0 10", out_ch, out_data);
    end
    in_valid = '0;
    tick();
  endtask

  task automatic test_single_ch();
    in_valid1 = 1'b1; in_data1 = 8'h5A; in_last1 = 1'b0; out_ready1 = 1'b1;
    #1;
    checks++;
    if (in_ready1 !== 1'b1) begin failures++; $display("FAIL one_rdy: got %b want 1", in_ready1); end
    tick();
    checks++;
    if (out_valid1 !== 1'b1 || out_ch1 !== 1'b0 || out_data1 !== 8'h5A || out_last1 !== 1'b0) begin
      failures++;
      $display("FAIL one_beat1: valid=%b ch=%0d data=%h last=%b, want 1 0 5a 0",
               out_valid1, out_ch1, out_data1, out_last1);
    end
    in_data1 = 8'h5B; in_last1 = 1'b1;
    tick();
    checks++;
    if (out_data1 !== 8'h5B || out_last1 !== 1'b1 || out_ch1 !== 1'b0) begin
      failures++;
      $display("FAIL one_beat2: data=%h last=%b ch=%0d, want 5b 1 0", out_data1, out_last1, out_ch1);
    end
    in_valid1 = 1'b0;
    tick();
  endtask

  initial begin
    test_reset();
    test_rr_single();
    test_lock();
    test_backpressure();
    test_force();
    test_reset_mid_packet();
    test_single_ch();
    tick();
    tick();
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL sb_drain: %0d beats never emerged, want 0", sb.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
